fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding and load-use hazard unit for the pipelined core; sits beside the ID/EX boundary.
//  Tracks the dest/write-enable/load flag of every in-flight instruction in an internal stage shift register.
//  Drives per-source bypass mux selects and a stall/bubble request. Replaces the 2-stage, 2-source combinational unit.
// PARAMETERS
//  NUM_SRC        2   source operands checked per issuing instruction
//  NUM_STAGES     3   tracked producer stages after ID (1=EX, 2=MEM, 3=WB, ...)
//  REG_AW         5   register address width
//  ZERO_REG       31  hard-wired zero register; never forwarded, never stalls
//  LOAD_READY_STG 2   first stage at which a load result can be forwarded
// PORTS
//  clk          in   1                  clock, all state on rising edge
//  reset        in   1                  asynchronous, active-high
//  id_valid     in   1                  instruction present in ID
//  id_src_addr  in   NUM_SRC*REG_AW     source reg addresses, src0 in LSBs
//  id_src_used  in   NUM_SRC            per-source read enable
//  id_dest      in   REG_AW             dest reg (Rd) of ID instruction
//  id_regwr     in   1                  ID instruction writes id_dest
//  id_is_load   in   1                  ID instruction is a load
//  hold         in   1                  global pipeline freeze (e.g. memory wait)
//  flush        in   1                  squash all in-flight instructions
//  fwd_sel      out  NUM_SRC*SEL_W      per source: 0=regfile, k=stage k; SEL_W=$clog2(NUM_STAGES+1)
//  stall        out  1                  hold PC/IF/ID, bubble into EX
// BEHAVIOUR
//  - Only clock is clk; reset is asynchronous and active-high. On reset: all stage entries invalid, stall=0, fwd_sel=0.
//  - State: entry[1..NUM_STAGES] = {valid, dest, regwr, is_load}.
//  - fwd_sel/stall are combinational from entries and ID inputs (zero latency).
//  - Match src i vs stage k: id_valid & id_src_used[i] & src!=ZERO_REG & entry[k].valid & regwr & dest==src.
//  - Priority: smallest k (youngest) wins; fwd_sel[i]=that k, else 0. No match -> 0.
//  - Load-use: if winning stage k < LOAD_READY_STG and entry[k].is_load -> stall=1, fwd_sel[i] is don't-care (drive 0).
//  - Stall ORs over all sources. A younger non-load match masks an older load match (no stall).
//  - Clock edge, priority order:
//    1. flush=1: all entries invalid; ID not captured (flush beats hold and stall).
//    2. hold=1: all entries keep their value; stall/fwd_sel still evaluated.
//    3. else shift: entry[k+1]<=entry[k]; entry[NUM_STAGES] retires.
//       entry[1] <= bubble (valid=0) if stall, else {id_valid, id_dest, id_regwr, id_is_load}.
//  - id_regwr with id_dest==ZERO_REG is captured but never matches (dest check).
//  - Default timing: load in EX + dependent in ID -> one stall cycle; next cycle fwd_sel=2 (MEM).
//  - Reset asserted mid-stall clears all entries immediately; stall drops at once.
// CONFIGURATION
//  FWD_STALL_CNT_EN defined:
//    Adds port stall_cnt (out, 32) counting cycles with stall=1 & hold=0 & flush=0.
//    Saturates at all-ones; reset to 0.
//  Undefined: no port, no counter logic; remaining behaviour identical.
// STRUCTURE
//  Package fwd_pkg:
//    fwd_entry_t struct {valid, dest, regwr, is_load}.
//    FWD_SEL_RF=0 constant.
//    sel_width(n) function.
//  Sub-module fwd_src_match: one source vs all entries.
//    Outputs the priority-encoded sel and a load_hazard bit.
//    Instantiated NUM_SRC times via generate; top ORs load_hazard into stall.
// TESTING
//  1. Defaults. EX={v,dest5,wr}, MEM={v,dest5,wr}, ID src0=5 -> fwd_sel0=1 (EX priority), stall=0.
//  2. Load-use. EX={v,dest7,wr,load}, ID src1=7 used -> stall=1.
//     Next edge: EX bubble, MEM holds load -> fwd_sel1=2, stall=0.
//  3. ZERO_REG. EX dest31 wr, ID src0=31 -> fwd_sel0=0, stall=0. Same with src_used=0 -> 0.
//  4. Hold/flush.
//     hold=1 for 3 cycles with load hazard -> entries frozen, stall stays 1.
//     flush=1 -> next cycle all selects 0, stall 0.
//  5. NUM_STAGES=4, NUM_SRC=3. Match only in stage 4 -> sel=4 (SEL_W=3); three sources resolve independently.
//  6. FWD_STALL_CNT_EN. 5 stall cycles, 2 of them with hold=1 -> stall_cnt=3. Async reset mid-run -> 0.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_pkg
//  Purpose  : Shared types and helpers for the forwarding / load-use hazard
//             unit (in-flight entry record, regfile select code, select width).
//  Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

   // Select code meaning "take the operand from the register file"
   localparam int FWD_SEL_RF = 0;

   // Storage width of a tracked destination; REG_AW must not exceed this
   localparam int FWD_DEST_W = 8;

   // One tracked in-flight instruction
   typedef struct packed {
      logic                  valid;
      logic [FWD_DEST_W-1:0] dest;
      logic                  regwr;
      logic                  is_load;
   } fwd_entry_t;

   // Bits needed to encode 0 (regfile) plus stages 1..n
   function automatic int sel_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_unit_if
//  Purpose  : ID-stage request and bypass/stall response bundle of the
//             forwarding / hazard unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface fwd_hazard_unit_if #(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 3,
   parameter int REG_AW     = 5
);
   import fwd_pkg::*;

   localparam int SEL_W = sel_width(NUM_STAGES);

   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_src_addr;
   logic [NUM_SRC-1:0]        id_src_used;
   logic [REG_AW-1:0]         id_dest;
   logic                      id_regwr;
   logic                      id_is_load;
   logic                      hold;
   logic                      flush;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
   logic                      stall;

   modport master (
      output id_valid, id_src_addr, id_src_used, id_dest, id_regwr, id_is_load,
             hold, flush,
      input  fwd_sel, stall
   );

   modport slave (
      input  id_valid, id_src_addr, id_src_used, id_dest, id_regwr, id_is_load,
             hold, flush,
      output fwd_sel, stall
   );

endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit_src_match.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_src_match
//  Purpose  : Resolves one source operand against every tracked stage:
//             youngest matching producer wins; a winning load that is not yet
//             forwardable raises load_hazard and forces the regfile select.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int NUM_STAGES     = 3,
   parameter int REG_AW         = 5,
   parameter int ZERO_REG       = 31,
   parameter int LOAD_READY_STG = 2,
   parameter int SEL_W          = sel_width(NUM_STAGES)
) (
   input  wire logic              id_valid,
   input  wire logic [REG_AW-1:0] src_addr,
   input  wire logic              src_used,
   input  wire fwd_entry_t        entries [1:NUM_STAGES],
   output logic [SEL_W-1:0]       sel,
   output logic                   load_hazard
);

   logic             w_active;
   logic [SEL_W-1:0] w_hit_stage;
   logic             w_hit_load;

   // The zero register is never a real dependency
   assign w_active = id_valid && src_used && (src_addr != REG_AW'(ZERO_REG));

   // Scan oldest to youngest so the youngest matching producer is written last
   always_comb begin
      w_hit_stage = SEL_W'(FWD_SEL_RF);
      w_hit_load  = 1'b0;
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (w_active && entries[k].valid && entries[k].regwr &&
             (entries[k].dest == FWD_DEST_W'(src_addr))) begin
            w_hit_stage = SEL_W'(k);
            w_hit_load  = entries[k].is_load && (k < LOAD_READY_STG);
         end
      end
   end

   assign sel         = w_hit_load ? SEL_W'(FWD_SEL_RF) : w_hit_stage;
   assign load_hazard = w_hit_load;

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_unit
//  Purpose  : Parametrised forwarding and load-use hazard unit beside ID/EX.
//             Keeps a shift register of in-flight {valid,dest,regwr,is_load}
//             and drives per-source bypass selects plus a stall request.
//  Options  : FWD_STALL_CNT_EN - adds saturating 32-bit stall_cnt output
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int NUM_SRC        = 2,
   parameter int NUM_STAGES     = 3,
   parameter int REG_AW         = 5,
   parameter int ZERO_REG       = 31,
   parameter int LOAD_READY_STG = 2
) (
   input  wire logic          clk,
   input  wire logic          reset,
   fwd_hazard_unit_if.slave   bus
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [31:0]        stall_cnt
`endif
);

   localparam int         SEL_W    = sel_width(NUM_STAGES);
   localparam fwd_entry_t c_bubble = '0;

   fwd_entry_t               r_entry [1:NUM_STAGES];
   fwd_entry_t               w_id_entry;
   logic [NUM_SRC-1:0]       w_load_hazard;
   logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
   logic                     w_stall;

   assign w_id_entry = '{valid:   bus.id_valid,
                         dest:    FWD_DEST_W'(bus.id_dest),
                         regwr:   bus.id_regwr,
                         is_load: bus.id_is_load};

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(
         .NUM_STAGES     (NUM_STAGES),
         .REG_AW         (REG_AW),
         .ZERO_REG       (ZERO_REG),
         .LOAD_READY_STG (LOAD_READY_STG),
         .SEL_W          (SEL_W)
      ) u_match (
         .id_valid    (bus.id_valid),
         .src_addr    (bus.id_src_addr[i*REG_AW +: REG_AW]),
         .src_used    (bus.id_src_used[i]),
         .entries     (r_entry),
         .sel         (w_fwd_sel[i*SEL_W +: SEL_W]),
         .load_hazard (w_load_hazard[i])
      );
   end

   assign w_stall     = |w_load_hazard;
   assign bus.fwd_sel = w_fwd_sel;
   assign bus.stall   = w_stall;

   // Stage tracker: flush squashes, hold freezes, otherwise advance one stage
   // and inject a bubble when the ID instruction is being held back
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 1; k <= NUM_STAGES; k++) r_entry[k] <= c_bubble;
      end else if (bus.flush) begin
         for (int k = 1; k <= NUM_STAGES; k++) r_entry[k].valid <= 1'b0;
      end else if (!bus.hold) begin
         for (int k = NUM_STAGES; k >= 2; k--) r_entry[k] <= r_entry[k-1];
         r_entry[1] <= w_stall ? c_bubble : w_id_entry;
      end
   end

`ifdef FWD_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Count cycles where a bubble really enters EX; saturate instead of wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !bus.hold && !bus.flush && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_hazard_unit
//  Purpose  : Self-checking bench for fwd_hazard_unit: default 2-src/3-stage
//             instance and a 3-src/4-stage instance, against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

   typedef struct {
      bit v;
      int dest;
      bit wr;
      bit ld;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fwd_hazard_unit_if #(.NUM_SRC(2), .NUM_STAGES(3), .REG_AW(5)) bus_a ();
   fwd_hazard_unit_if #(.NUM_SRC(3), .NUM_STAGES(4), .REG_AW(5)) bus_b ();

`ifdef FWD_STALL_CNT_EN
   logic [31:0] stall_cnt_a;
   logic [31:0] stall_cnt_b;
`endif

   fwd_hazard_unit #(.NUM_SRC(2), .NUM_STAGES(3), .REG_AW(5), .ZERO_REG(31),
                     .LOAD_READY_STG(2)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
`ifdef FWD_STALL_CNT_EN
      , .stall_cnt (stall_cnt_a)
`endif
   );

   fwd_hazard_unit #(.NUM_SRC(3), .NUM_STAGES(4), .REG_AW(5), .ZERO_REG(31),
                     .LOAD_READY_STG(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
`ifdef FWD_STALL_CNT_EN
      , .stall_cnt (stall_cnt_b)
`endif
   );

   // Model: queue index 0 is stage 1 (EX), index 1 is MEM, ...
   ent_t        qa[$];
   ent_t        qb[$];
   int unsigned cnt_a;
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic void reset_models();
      ent_t e;
      e = '{v: 1'b0, dest: 0, wr: 1'b0, ld: 1'b0};
      qa = {};
      qb = {};
      for (int j = 0; j < 3; j++) qa.push_back(e);
      for (int j = 0; j < 4; j++) qb.push_back(e);
      cnt_a = 0;
   endfunction

   // Find the youngest producer of src; loads not yet in MEM cannot forward
   function automatic void resolve(input ent_t q[$], input bit idv, input bit used,
                                   input int src, output int sel, output bit haz);
      bit found;
      sel   = 0;
      haz   = 1'b0;
      found = 1'b0;
      if (idv && used && src != 31) begin
         for (int j = 0; j < q.size(); j++) begin
            if (!found && q[j].v && q[j].wr && q[j].dest == src) begin
               found = 1'b1;
               if (q[j].ld && (j + 1) < 2) haz = 1'b1;
               else sel = j + 1;
            end
         end
      end
   endfunction

   function automatic void expect_a(output logic [3:0] sel, output logic st);
      int s;
      bit h;
      sel = '0;
      st  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         resolve(qa, bus_a.id_valid, bus_a.id_src_used[i],
                 int'(bus_a.id_src_addr[i*5 +: 5]), s, h);
         sel[i*2 +: 2] = 2'(s);
         st = st | h;
      end
   endfunction

   function automatic void expect_b(output logic [8:0] sel, output logic st);
      int s;
      bit h;
      sel = '0;
      st  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         resolve(qb, bus_b.id_valid, bus_b.id_src_used[i],
                 int'(bus_b.id_src_addr[i*5 +: 5]), s, h);
         sel[i*3 +: 3] = 3'(s);
         st = st | h;
      end
   endfunction

   // One clock: advance both models with the inputs present at the edge
   task automatic tick();
      logic [3:0] sa;
      logic       sta;
      logic [8:0] sb;
      logic       stb;
      ent_t       e;
      expect_a(sa, sta);
      expect_b(sb, stb);
      @(posedge clk);
      if (!reset) begin
         if (sta && !bus_a.hold && !bus_a.flush && cnt_a != 32'hFFFF_FFFF) cnt_a++;
         if (bus_a.flush) begin
            foreach (qa[j]) qa[j].v = 1'b0;
         end else if (!bus_a.hold) begin
            e = '{v: bus_a.id_valid, dest: int'(bus_a.id_dest), wr: bus_a.id_regwr, ld: bus_a.id_is_load};
            if (sta) e = '{v: 1'b0, dest: 0, wr: 1'b0, ld: 1'b0};
            void'(qa.pop_back());
            qa.push_front(e);
         end
         if (bus_b.flush) begin
            foreach (qb[j]) qb[j].v = 1'b0;
         end else if (!bus_b.hold) begin
            e = '{v: bus_b.id_valid, dest: int'(bus_b.id_dest), wr: bus_b.id_regwr, ld: bus_b.id_is_load};
            if (stb) e = '{v: 1'b0, dest: 0, wr: 1'b0, ld: 1'b0};
            void'(qb.pop_back());
            qb.push_front(e);
         end
      end
      #1;
   endtask

   task automatic drive_a(input bit v, input logic [9:0] srcs, input logic [1:0] used,
                          input logic [4:0] dest, input bit wr, input bit ld,
                          input bit hold, input bit flush);
      bus_a.id_valid    = v;
      bus_a.id_src_addr = srcs;
      bus_a.id_src_used = used;
      bus_a.id_dest     = dest;
      bus_a.id_regwr    = wr;
      bus_a.id_is_load  = ld;
      bus_a.hold        = hold;
      bus_a.flush       = flush;
      #1;
   endtask

   task automatic drive_b(input bit v, input logic [14:0] srcs, input logic [2:0] used,
                          input logic [4:0] dest, input bit wr, input bit ld,
                          input bit hold, input bit flush);
      bus_b.id_valid    = v;
      bus_b.id_src_addr = srcs;
      bus_b.id_src_used = used;
      bus_b.id_dest     = dest;
      bus_b.id_regwr    = wr;
      bus_b.id_is_load  = ld;
      bus_b.hold        = hold;
      bus_b.flush       = flush;
      #1;
   endtask

   function automatic logic [4:0] rnd_reg();
      int r;
      r = $urandom_range(0, 8);
      return (r == 8) ? 5'd31 : 5'(r);
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      drive_a(1, {5'd3, 5'd3}, 2'b11, 5'd3, 1, 1, 0, 0);
      drive_b(1, {5'd3, 5'd3, 5'd3}, 3'b111, 5'd3, 1, 1, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      n_tests++;
      if (bus_a.fwd_sel !== 4'd0 || bus_a.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a: fwd_sel=%h stall=%b expected 0/0", bus_a.fwd_sel, bus_a.stall);
      end
      n_tests++;
      if (bus_b.fwd_sel !== 9'd0 || bus_b.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_b: fwd_sel=%h stall=%b expected 0/0", bus_b.fwd_sel, bus_b.stall);
      end
      drive_a(0, 10'd0, 2'b00, 5'd0, 0, 0, 0, 0);
      drive_b(0, 15'd0, 3'b000, 5'd0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      reset_models();
      @(posedge clk);
      #1;
   endtask

   task automatic test_defaults();
      logic [3:0] es;
      logic       est;
      drive_a(1, 10'd0, 2'b00, 5'd5, 1, 0, 0, 0);
      tick();
      drive_a(1, 10'd0, 2'b00, 5'd5, 1, 0, 0, 0);
      tick();
      drive_a(1, {5'd0, 5'd5}, 2'b01, 5'd9, 0, 0, 0, 0);
      expect_a(es, est);
      n_tests++;
      if (bus_a.fwd_sel !== 4'b0001 || bus_a.stall !== 1'b0 ||
          bus_a.fwd_sel !== es || bus_a.stall !== est) begin
         n_fail++;
         $display("FAIL defaults_ex_priority: fwd_sel=%h stall=%b expected 1/0 (model %h/%b)",
                  bus_a.fwd_sel, bus_a.stall, es, est);
      end
      tick();
   endtask

   task automatic test_load_use();
      drive_a(1, 10'd0, 2'b00, 5'd7, 1, 1, 0, 0);
      tick();
      drive_a(1, {5'd7, 5'd0}, 2'b10, 5'd3, 1, 0, 0, 0);
      n_tests++;
      if (bus_a.stall !== 1'b1 || bus_a.fwd_sel !== 4'b0000) begin
         n_fail++;
         $display("FAIL load_use_stall: fwd_sel=%h stall=%b expected 0/1", bus_a.fwd_sel, bus_a.stall);
      end
      tick();
      n_tests++;
      if (bus_a.stall !== 1'b0 || bus_a.fwd_sel !== 4'b1000) begin
         n_fail++;
         $display("FAIL load_use_mem_fwd: fwd_sel=%h stall=%b expected 8/0", bus_a.fwd_sel, bus_a.stall);
      end
      tick();
   endtask

   task automatic test_zero_reg();
      drive_a(1, 10'd0, 2'b00, 5'd31, 1, 1, 0, 0);
      tick();
      drive_a(1, {5'd0, 5'd31}, 2'b01, 5'd4, 0, 0, 0, 0);
      n_tests++;
      if (bus_a.fwd_sel !== 4'd0 || bus_a.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_reg_used: fwd_sel=%h stall=%b expected 0/0", bus_a.fwd_sel, bus_a.stall);
      end
      drive_a(1, {5'd0, 5'd31}, 2'b00, 5'd4, 0, 0, 0, 0);
      n_tests++;
      if (bus_a.fwd_sel !== 4'd0 || bus_a.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_reg_unused: fwd_sel=%h stall=%b expected 0/0", bus_a.fwd_sel, bus_a.stall);
      end
      tick();
   endtask

   task automatic test_hold_flush();
      drive_a(1, 10'd0, 2'b00, 5'd12, 1, 1, 0, 0);
      tick();
      for (int c = 0; c < 3; c++) begin
         drive_a(1, {5'd0, 5'd12}, 2'b01, 5'd2, 1, 0, 1, 0);
         n_tests++;
         if (bus_a.stall !== 1'b1 || bus_a.fwd_sel !== 4'd0) begin
            n_fail++;
            $display("FAIL hold_stall_c%0d: fwd_sel=%h stall=%b expected 0/1", c, bus_a.fwd_sel, bus_a.stall);
         end
         tick();
      end
      drive_a(1, {5'd0, 5'd12}, 2'b01, 5'd2, 1, 0, 1, 1);
      tick();
      drive_a(1, {5'd0, 5'd12}, 2'b01, 5'd2, 1, 0, 0, 0);
      n_tests++;
      if (bus_a.stall !== 1'b0 || bus_a.fwd_sel !== 4'd0) begin
         n_fail++;
         $display("FAIL flush_clear: fwd_sel=%h stall=%b expected 0/0", bus_a.fwd_sel, bus_a.stall);
      end
      tick();
   endtask

   task automatic test_wide();
      logic [8:0] es;
      logic       est;
      for (int d = 20; d <= 23; d++) begin
         drive_b(1, 15'd0, 3'b000, 5'(d), 1, 0, 0, 0);
         tick();
      end
      drive_b(1, {5'd0, 5'd0, 5'd20}, 3'b001, 5'd1, 0, 0, 0, 0);
      n_tests++;
      if (bus_b.fwd_sel !== 9'b000_000_100 || bus_b.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_stage4: fwd_sel=%h stall=%b expected 004/0", bus_b.fwd_sel, bus_b.stall);
      end
      drive_b(1, {5'd23, 5'd22, 5'd20}, 3'b111, 5'd1, 0, 0, 0, 0);
      expect_b(es, est);
      n_tests++;
      if (bus_b.fwd_sel !== 9'b001_010_100 || bus_b.stall !== 1'b0 ||
          bus_b.fwd_sel !== es || bus_b.stall !== est) begin
         n_fail++;
         $display("FAIL wide_three_src: fwd_sel=%h stall=%b expected 054/0 (model %h/%b)",
                  bus_b.fwd_sel, bus_b.stall, es, est);
      end
      tick();
   endtask

   task automatic test_random();
      logic [3:0] ea;
      logic       sa;
      logic [8:0] eb;
      logic       sb;
      for (int c = 0; c < 300; c++) begin
         drive_a($urandom_range(0, 9) != 0, {rnd_reg(), rnd_reg()}, 2'($urandom_range(0, 3)),
                 rnd_reg(), $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
         drive_b($urandom_range(0, 9) != 0, {rnd_reg(), rnd_reg(), rnd_reg()},
                 3'($urandom_range(0, 7)), rnd_reg(), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0);
         expect_a(ea, sa);
         expect_b(eb, sb);
         n_tests++;
         if (bus_a.fwd_sel !== ea || bus_a.stall !== sa) begin
            n_fail++;
            $display("FAIL random_a c%0d: fwd_sel=%h stall=%b expected %h/%b", c, bus_a.fwd_sel, bus_a.stall, ea, sa);
         end
         n_tests++;
         if (bus_b.fwd_sel !== eb || bus_b.stall !== sb) begin
            n_fail++;
            $display("FAIL random_b c%0d: fwd_sel=%h stall=%b expected %h/%b", c, bus_b.fwd_sel, bus_b.stall, eb, sb);
         end
         tick();
      end
      drive_a(0, 10'd0, 2'b00, 5'd0, 0, 0, 0, 1);
      drive_b(0, 15'd0, 3'b000, 5'd0, 0, 0, 0, 1);
      tick();
      drive_b(0, 15'd0, 3'b000, 5'd0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_stall();
      drive_a(1, 10'd0, 2'b00, 5'd6, 1, 1, 0, 0);
      tick();
      drive_a(1, {5'd0, 5'd6}, 2'b01, 5'd2, 1, 0, 0, 0);
      n_tests++;
      if (bus_a.stall !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_stall: stall=%b expected 1", bus_a.stall);
      end
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if (bus_a.stall !== 1'b0 || bus_a.fwd_sel !== 4'd0) begin
         n_fail++;
         $display("FAIL async_reset_mid_stall: fwd_sel=%h stall=%b expected 0/0", bus_a.fwd_sel, bus_a.stall);
      end
      reset_models();
      drive_a(0, 10'd0, 2'b00, 5'd0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

`ifdef FWD_STALL_CNT_EN
   task automatic test_stall_cnt();
      reset = 1'b1;
      reset_models();
      #1;
      n_tests++;
      if (stall_cnt_a !== 32'd0 || stall_cnt_b !== 32'd0) begin
         n_fail++;
         $display("FAIL stall_cnt_reset: a=%0d b=%0d expected 0", stall_cnt_a, stall_cnt_b);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int it = 0; it < 3; it++) begin
         drive_a(1, 10'd0, 2'b00, 5'd9, 1, 1, 0, 0);
         tick();
         if (it < 2) begin
            drive_a(1, {5'd0, 5'd9}, 2'b01, 5'd2, 0, 0, 1, 0);
            tick();
         end
         drive_a(1, {5'd0, 5'd9}, 2'b01, 5'd2, 0, 0, 0, 0);
         tick();
      end
      n_tests++;
      if (stall_cnt_a !== 32'd3 || stall_cnt_a !== cnt_a) begin
         n_fail++;
         $display("FAIL stall_cnt_count: got %0d expected 3 (model %0d)", stall_cnt_a, cnt_a);
      end
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if (stall_cnt_a !== 32'd0) begin
         n_fail++;
         $display("FAIL stall_cnt_async_reset: got %0d expected 0", stall_cnt_a);
      end
      reset_models();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive_a(0, 10'd0, 2'b00, 5'd0, 0, 0, 0, 0);
      drive_b(0, 15'd0, 3'b000, 5'd0, 0, 0, 0, 0);
      reset_models();
      test_reset();
      test_defaults();
      test_load_use();
      test_zero_reg();
      test_hold_flush();
      test_wide();
      test_random();
      test_reset_mid_stall();
`ifdef FWD_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
